// File: rtl/univ_shift_reg.sv
// Universal shift register: load, shift, rotate, arithmetic shift and clear, with a saturating count of shift ops.
// One-cycle latency on q/sout/cnt; done decodes the registered count; no backpressure, en=0 simply holds all state.
module univ_shift_reg #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  localparam int                CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;

  // Saturates at WIDTH so done stays asserted through further shifts.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    cnt_d  = cnt_q;
    if (en) begin
      case (mode)
        MODE_HOLD: ;
        MODE_LOAD: begin
          q_d   = din;
          cnt_d = '0;
        end
        MODE_SHL: begin
          q_d    = {q_q[WIDTH-2:0], sin};
          sout_d = q_q[WIDTH-1];
          cnt_d  = cnt_inc;
        end
        MODE_SHR: begin
          q_d    = {sin, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
          cnt_d  = cnt_inc;
        end
        MODE_ROL: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d = q_q[WIDTH-1];
          cnt_d  = cnt_inc;
        end
        MODE_ROR: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
          cnt_d  = cnt_inc;
        end
        MODE_ASR: begin
          q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
          cnt_d  = cnt_inc;
        end
        MODE_CLR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q    <= RST_VAL;
      sout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign cnt  = cnt_q;
  assign done = (cnt_q == CNT_MAX);

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 The block SHALL provide parameter RST_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 The block SHALL define local constant CW = clog2(WIDTH+1), the width of cnt.
REQ-004 Port clk, input, 1, clock; all state updates on its rising edge only.
REQ-005 Port rst_n, input, 1, reset: synchronous, active-low, sampled on the rising edge of clk.
REQ-006 Port en, input, 1, operation enable; 0 means hold all state.
REQ-007 Port mode, input, 3, operation select, decoded per REQ-012.
REQ-008 Port din, input, WIDTH, parallel load data.
REQ-009 Port sin, input, 1, serial input bit.
REQ-010 Port q, output, WIDTH, registered register contents.
REQ-011 Ports sout (output, 1, registered last bit shifted or rotated out), cnt (output, CW, registered shift-operation count) and done (output, 1, combinational, high when cnt == WIDTH).

Function
REQ-012 When rst_n=1 and en=1, the block SHALL apply mode at each rising edge:
- 000 hold: q unchanged.
- 001 load: q <= din.
- 010 shift left: q <= {q[W-2:0], sin}.
- 011 shift right logical: q <= {sin, q[W-1:1]}.
- 100 rotate left: q <= {q[W-2:0], q[W-1]}.
- 101 rotate right: q <= {q[0], q[W-1:1]}.
- 110 arithmetic shift right: q <= {q[W-1], q[W-1:1]}; sin ignored.
- 111 clear: q <= 0.
REQ-013 On modes 010 and 100, sout SHALL take the old q[W-1]; on modes 011, 101 and 110, sout SHALL take the old q[0]; on all other modes sout SHALL hold.
REQ-014 On modes 010 through 110, cnt SHALL increment by 1 and saturate at WIDTH, never wrapping.
REQ-015 On modes 001 and 111, cnt SHALL clear to 0 in the same edge as the q update.
REQ-016 On mode 000, cnt SHALL hold.
REQ-017 When en=0, q, sout and cnt SHALL all hold regardless of mode, din and sin.
REQ-018 Latency SHALL be one clock: the result of an operation is visible on q, sout and cnt immediately after the edge that samples it.
REQ-019 done SHALL be derived only from the registered cnt, with no path from any input.
REQ-020 After WIDTH consecutive rotates in the same direction, q SHALL equal its value before the first rotate, and done SHALL be 1.
REQ-021 When cnt = WIDTH, further shifts SHALL still update q and sout while cnt stays at WIDTH and done stays 1.

Reset
REQ-022 Priority at each edge SHALL be rst_n over en, and en over mode.
REQ-023 When rst_n=0 at an edge, q SHALL load RST_VAL and sout and cnt SHALL load 0, regardless of en and mode.
REQ-024 Reset asserted mid-sequence SHALL abort the sequence, and the first operation after reset releases SHALL act on RST_VAL.
REQ-025 Deasserting rst_n between edges SHALL have no effect until the next rising edge.

Verification (WIDTH=8, RST_VAL=8'hA5)
REQ-026 Scenario reset: rst_n=0 for 2 edges with en=1 and mode=001, din=FF -> q=A5, sout=0, cnt=0, done=0.
REQ-027 Scenario load and shift: load 8'h81, then 3 shift-left edges with sin=1,0,1 -> q=0D, sout=0, cnt=3.
REQ-028 Scenario rotate and done: load 8'hC3, then 8 rotate-right edges -> q=C3, cnt=8, done=1; a 9th edge -> q=E1, cnt=8, done=1.
REQ-029 Scenario arithmetic shift: load 8'h90, then 2 arithmetic-shift-right edges -> q=E4, sout=0, cnt=2.
REQ-030 Scenario enable gating: load 8'h3C, then 4 edges with en=0 and mode=010 -> q=3C, cnt=0; a clear edge -> q=00, cnt=0.
REQ-031 Scenario mid-operation reset: rst_n=0 on the 3rd of 5 shifts -> q=A5, cnt=0 at that edge; after release, one shift-right with sin=0 -> q=52, sout=1, cnt=1.
